// File: rtl/fir_structs.sv
`default_nettype none
// ============================================================================
// Module   : fir_structs (package)
// Purpose  : Shared types and constants for the FIR complex datapath.
//            Holds the packed output-sample record and the default output
//            width / rounding shift used by firc_out_packer.
// Revision : 1.0  initial release
// ============================================================================
package fir_structs;

  // Default output width per component and number of LSBs dropped by rounding.
  localparam int FIRC_OUT_W     = 24;
  localparam int FIRC_OUT_SHIFT = 8;

  // One rounded/saturated complex output sample.
  typedef struct packed {
    logic signed [FIRC_OUT_W-1:0] I;
    logic signed [FIRC_OUT_W-1:0] Q;
  } OutSamp;

endpackage : fir_structs
`default_nettype wire

// File: rtl/firc_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : firc_round_sat
// Purpose  : Combinational round-half-up and saturate of a signed 32-bit
//            value down to a signed OUT_W-bit value.
// Ports    : x_i   [31:0]      signed input
//            y_o   [OUT_W-1:0] signed rounded/clamped output
//            sat_o             high when the result was clamped
// Revision : 1.0  initial release
// ============================================================================
module firc_round_sat #(
  parameter int OUT_W = 24,
  parameter int SHIFT = 8
) (
  input  logic [31:0]      x_i,
  output logic [OUT_W-1:0] y_o,
  output logic             sat_o
);

  // 33-bit working width: the rounding add can never overflow it.
  localparam logic signed [32:0] RND   = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] MAX_V = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (OUT_W - 1));

  logic signed [32:0] sum_w;
  logic signed [32:0] r_w;

  always_comb begin
    sum_w = $signed({x_i[31], x_i}) + RND;
    r_w   = sum_w >>> SHIFT;
    y_o   = r_w[OUT_W-1:0];
    sat_o = 1'b0;
    if (r_w > MAX_V) begin
      y_o   = MAX_V[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (r_w < MIN_V) begin
      y_o   = MIN_V[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule : firc_round_sat
`default_nettype wire

// File: rtl/firc_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : firc_out_packer
// Purpose  : Rounds/saturates the FIR complex result stream to OUT_W bits,
//            buffers it in a DEPTH-entry FIFO and presents a valid/ready
//            stream. The input has no backpressure; results arriving while
//            the FIFO is full (and not popping) are dropped and flagged.
// Ports    : clk, Reset (async, active high)
//            PushIn, FI, FQ        FIR result stream in
//            OutValid, OutReady    output handshake
//            OutI, OutQ            head-of-FIFO entry (combinational read)
//            Count                 FIFO occupancy
//            Overflow, SatSeen     sticky status flags
//            DropCnt               saturating drop counter (optional)
// Options  : FIRC_OUT_DROPCNT_EN - when defined, adds the DropCnt output.
// Revision : 1.0  initial release
// ============================================================================
module firc_out_packer
  import fir_structs::*;
#(
  parameter int DEPTH = 8,
  parameter int OUT_W = FIRC_OUT_W,
  parameter int SHIFT = FIRC_OUT_SHIFT
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     PushIn,
  input  logic [31:0]              FI,
  input  logic [31:0]              FQ,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [OUT_W-1:0]         OutI,
  output logic [OUT_W-1:0]         OutQ,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
`ifdef FIRC_OUT_DROPCNT_EN
  output logic [15:0]              DropCnt,
`endif
  output logic                     SatSeen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * OUT_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // --------------------------------------------------------------------------
  // Stage 1: round + saturate, registered
  // --------------------------------------------------------------------------
  logic [OUT_W-1:0] i_rs_w, q_rs_w;
  logic             i_sat_w, q_sat_w;

  firc_round_sat #(.OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_i (
    .x_i   (FI),
    .y_o   (i_rs_w),
    .sat_o (i_sat_w)
  );

  firc_round_sat #(.OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_q (
    .x_i   (FQ),
    .y_o   (q_rs_w),
    .sat_o (q_sat_w)
  );

  logic             s1_valid_q;
  logic [OUT_W-1:0] s1_i_q, s1_q_q;
  logic             sat_seen_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      sat_seen_q <= 1'b0;
    end else begin
      s1_valid_q <= PushIn;
      if (PushIn) begin
        s1_i_q <= i_rs_w;
        s1_q_q <= q_rs_w;
        if (i_sat_w || q_sat_w) begin
          sat_seen_q <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: FIFO (sync write, async read)
  // --------------------------------------------------------------------------
  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q;
  logic           pop_w, full_w, wr_en_w, drop_w;
  logic [EW-1:0]  rd_entry_w;

  assign pop_w   = (count_q != '0) && OutReady;
  assign full_w  = (count_q == FULL_CNT);
  // A full FIFO still accepts a write when the same edge pops the head.
  assign wr_en_w = s1_valid_q && (!full_w || pop_w);
  assign drop_w  = s1_valid_q && full_w && !pop_w;

  always_comb begin
    count_d = count_q;
    case ({wr_en_w, pop_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (wr_en_w) begin
      mem_q[wr_ptr_q] <= {s1_i_q, s1_q_q};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_w)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop_w) overflow_q <= 1'b1;
    end
  end

`ifdef FIRC_OUT_DROPCNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      drop_cnt_q <= '0;
    end else if (drop_w && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign DropCnt = drop_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_entry_w = mem_q[rd_ptr_q];
  assign OutValid   = (count_q != '0);
  // Forced to zero while empty so the outputs never expose stale storage.
  assign OutI       = OutValid ? rd_entry_w[EW-1:OUT_W] : '0;
  assign OutQ       = OutValid ? rd_entry_w[OUT_W-1:0]  : '0;
  assign Count      = count_q;
  assign Overflow   = overflow_q;
  assign SatSeen    = sat_seen_q;

endmodule : firc_out_packer
`default_nettype wire

// File: tb/tb_firc_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_firc_out_packer
// Purpose  : Directed self-checking bench for firc_out_packer (defaults
//            DEPTH=8, OUT_W=24, SHIFT=8). Inputs change and outputs are
//            sampled on the falling clock edge.
// Options  : FIRC_OUT_DROPCNT_EN - also checks the DropCnt output.
// Revision : 1.0  initial release
// ============================================================================
module tb_firc_out_packer;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PushIn = 1'b0;
  logic [31:0] FI = '0;
  logic [31:0] FQ = '0;
  logic        OutReady = 1'b0;
  logic        OutValid;
  logic [23:0] OutI, OutQ;
  logic [3:0]  Count;
  logic        Overflow, SatSeen;
`ifdef FIRC_OUT_DROPCNT_EN
  logic [15:0] DropCnt;
`endif

  firc_out_packer #(.DEPTH(8), .OUT_W(24), .SHIFT(8)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .PushIn   (PushIn),
    .FI       (FI),
    .FQ       (FQ),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutI     (OutI),
    .OutQ     (OutQ),
    .Count    (Count),
    .Overflow (Overflow),
`ifdef FIRC_OUT_DROPCNT_EN
    .DropCnt  (DropCnt),
`endif
    .SatSeen  (SatSeen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [23:0] e24;
    int          nxt;
    int          maxcnt;

    // ---------------- reset state ----------------
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", OutValid, 0);
    chk("rst_outi", OutI, 0);
    chk("rst_outq", OutQ, 0);
    chk("rst_count", Count, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_sat", SatSeen, 0);
    Reset = 1'b0;

    // ---------------- rounding and latency ----------------
    // 0x180 = 384 -> (384+128)>>8 = 2 ; -384 -> (-256)>>>8 = -1
    OutReady = 1'b1;
    PushIn = 1'b1; FI = 32'h0000_0180; FQ = 32'hFFFF_FE80;
    step();
    PushIn = 1'b0;
    chk("lat_e0_valid", OutValid, 0);
    step();
    chk("lat_e1_valid", OutValid, 1);
    chk("rnd_outi", OutI, 24'h000002);
    chk("rnd_outq", OutQ, 24'hFFFFFF);
    chk("rnd_sat", SatSeen, 0);
    step();
    chk("rnd_popped", Count, 0);

    // ---------------- saturation ----------------
    PushIn = 1'b1; FI = 32'h7FFF_FFFF; FQ = 32'h8000_0000;
    step();
    PushIn = 1'b0;
    chk("sat_flag", SatSeen, 1);
    step();
    chk("sat_outi", OutI, 24'h7FFFFF);
    chk("sat_outq", OutQ, 24'h800000);
    step();
    PushIn = 1'b1; FI = 32'h0; FQ = 32'h0;
    step();
    PushIn = 1'b0;
    step();
    chk("sat_zero_outi", OutI, 0);
    chk("sat_sticky", SatSeen, 1);
    step();
    chk("sat_drained", Count, 0);

    // ---------------- fill, overflow, drain ----------------
    OutReady = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      PushIn = 1'b1; FI = 32'(k * 256); FQ = 32'(-(k * 256));
      step();
    end
    PushIn = 1'b0;
    step();
    chk("fill_count", Count, 8);
    chk("fill_ovf", Overflow, 0);
    chk("fill_head", OutI, 1);
    PushIn = 1'b1; FI = 32'(9 * 256); FQ = 32'(-(9 * 256));
    step();
    PushIn = 1'b0;
    step();
    chk("drop_ovf", Overflow, 1);
    chk("drop_count", Count, 8);
`ifdef FIRC_OUT_DROPCNT_EN
    chk("drop_cnt", DropCnt, 1);
`endif
    OutReady = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      e24 = 24'(-k);
      chk("drain_outi", OutI, 24'(k));
      chk("drain_outq", OutQ, e24);
      step();
    end
    chk("drain_empty_cnt", Count, 0);
    chk("drain_empty_valid", OutValid, 0);

    // ---------------- full FIFO: write + pop on same edge ----------------
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst2_ovf", Overflow, 0);
    OutReady = 1'b0;
    for (int k = 11; k <= 18; k++) begin
      PushIn = 1'b1; FI = 32'(k * 256); FQ = 32'h0;
      step();
    end
    PushIn = 1'b1; FI = 32'(19 * 256);
    step();
    // 18 just written, 19 waits in stage 1 with the FIFO full
    PushIn = 1'b0;
    chk("wp_full_before", Count, 8);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    chk("wp_count", Count, 8);
    chk("wp_ovf", Overflow, 0);
    OutReady = 1'b1;
    for (int k = 12; k <= 19; k++) begin
      chk("wp_drain", OutI, 24'(k));
      step();
    end
    chk("wp_empty", Count, 0);

    // ---------------- continuous streaming ----------------
    nxt = 100;
    maxcnt = 0;
    OutReady = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) begin
        PushIn = 1'b1; FI = 32'((100 + i) * 256); FQ = 32'(-((100 + i) * 256));
      end else begin
        PushIn = 1'b0;
      end
      step();
      if (int'(Count) > maxcnt) maxcnt = int'(Count);
      if (OutValid) begin
        e24 = 24'(-nxt);
        chk("stream_outi", OutI, 24'(nxt));
        chk("stream_outq", OutQ, e24);
        nxt++;
      end
    end
    PushIn = 1'b0;
    chk("stream_total", nxt - 100, 20);
    chk("stream_maxcnt_le2", (maxcnt <= 2), 1);

    // ---------------- async reset mid-operation ----------------
    OutReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      PushIn = 1'b1; FI = 32'((200 + i) * 256); FQ = 32'h0;
      step();
    end
    PushIn = 1'b0;
    chk("ar_count5", Count, 5);
    Reset = 1'b1;
    #1;
    chk("ar_valid", OutValid, 0);
    chk("ar_count", Count, 0);
    chk("ar_ovf", Overflow, 0);
    step();
    Reset = 1'b0;
    step();
    chk("ar_inflight_gone", Count, 0);
    PushIn = 1'b1; FI = 32'(300 * 256); FQ = 32'h0;
    step();
    PushIn = 1'b0;
    step();
    chk("ar_clean_count", Count, 1);
    chk("ar_clean_outi", OutI, 24'd300);
    OutReady = 1'b1;
    step();
    chk("ar_clean_empty", Count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_firc_out_packer
`default_nettype wire
